// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the PC, issues one imem read per cycle while
// FIFO credit allows, buffers {pc, instr} pairs and hands them to decode.
module fetch_unit #(
  parameter int              PC_W     = 64,
  parameter int              INSTR_W  = 32,
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               dec_valid,
  output logic [INSTR_W-1:0] dec_instr,
  output logic [PC_W-1:0]    dec_pc,
  input  logic               dec_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  logic [PC_W-1:0]    pc;
  logic [PC_W-1:0]    inflight_pc;
  logic               inflight;
  logic               kill;
  logic               redirect_d;
  logic [AW-1:0]      rd_ptr;
  logic [AW-1:0]      wr_ptr;
  logic [CW-1:0]      count;
  logic [PC_W-1:0]    pc_mem    [DEPTH];
  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic [CW:0]        used;
  logic               push;
  logic               pop;

  // Credit counts the in-flight read so a response always has a slot waiting.
  assign used      = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign imem_req  = !reset && !redirect_valid && !redirect_d && (used < DEPTH_C);
  assign imem_addr = pc;
  assign dec_valid = (count != '0);
  assign dec_instr = instr_mem[rd_ptr];
  assign dec_pc    = pc_mem[rd_ptr];
  assign push      = inflight && !kill;
  assign pop       = dec_valid && dec_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      inflight_pc <= '0;
      inflight    <= 1'b0;
      kill        <= 1'b0;
      redirect_d  <= 1'b0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else begin
      redirect_d <= redirect_valid;
      kill       <= redirect_valid;
      inflight   <= imem_req;
      if (imem_req)
        inflight_pc <= pc;
      // Redirect wins over push and pop; the response landing now is dropped.
      if (redirect_valid) begin
        pc     <= {redirect_pc[PC_W-1:2], 2'b00};
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (imem_req)
          pc <= pc + PC_W'(4);
        if (push) begin
          pc_mem[wr_ptr]    <= inflight_pc;
          instr_mem[wr_ptr] <= imem_rdata;
          wr_ptr            <= wr_ptr + AW'(1);
        end
        if (pop)
          rd_ptr <= rd_ptr + AW'(1);
        if (push && !pop)
          count <= count + CW'(1);
        else if (!push && pop)
          count <= count - CW'(1);
      end
    end
  end

endmodule
